// File: rtl/pe_mem_scheduler_if.sv
// Bus between the PE request fabric, the scheduler and the PE memory datapath.
// The scheduler attaches through the slave modport; the request/memory side
// attaches through the master modport.
interface pe_mem_scheduler_if #(
  parameter int WORD_SIZE        = 256,
  parameter int NOF_PES          = 16,
  parameter int NOF_LEVELS       = $clog2(NOF_PES),
  parameter int GROUP_SIZE_WIDTH = NOF_LEVELS + 1
);

  // request fabric side
  logic [NOF_PES-1:0]                  req;
  logic [NOF_PES*NOF_LEVELS-1:0]       req_dest;
  logic [NOF_PES*GROUP_SIZE_WIDTH-1:0] req_group_size;
  logic [NOF_PES*WORD_SIZE-1:0]        req_data;
  logic [NOF_PES-1:0]                  grant;
  logic                                busy;

  // memory datapath side
  logic [WORD_SIZE-1:0]                mem_input_data;
  logic [NOF_LEVELS-1:0]               mem_src_pe_index;
  logic [NOF_LEVELS-1:0]               mem_dest_pe_index;
  logic                                mem_valid;
  logic [WORD_SIZE-1:0]                mem_output_data;

  // registered response
  logic                                rsp_valid;
  logic [NOF_LEVELS-1:0]               rsp_pe_index;
  logic [NOF_LEVELS-1:0]               rsp_dest_index;
  logic [WORD_SIZE-1:0]                rsp_data;
  logic                                rsp_last;

  modport master (
    output req, req_dest, req_group_size, req_data, mem_output_data,
    input  grant, busy, mem_input_data, mem_src_pe_index, mem_dest_pe_index,
           mem_valid, rsp_valid, rsp_pe_index, rsp_dest_index, rsp_data, rsp_last
  );

  modport slave (
    input  req, req_dest, req_group_size, req_data, mem_output_data,
    output grant, busy, mem_input_data, mem_src_pe_index, mem_dest_pe_index,
           mem_valid, rsp_valid, rsp_pe_index, rsp_dest_index, rsp_data, rsp_last
  );

endinterface

// File: rtl/pe_mem_scheduler.sv
// Round-robin arbiter and burst sequencer sharing the single-port PE memory
// between NOF_PES requesters. A winner's command is latched on its grant
// cycle, then one memory beat per cycle walks the dest group (wrapping mod
// NOF_PES); each beat's read word comes back one cycle later as a response.
module pe_mem_scheduler #(
  parameter int WORD_SIZE        = 256,
  parameter int NOF_PES          = 16,
  parameter int NOF_LEVELS       = $clog2(NOF_PES),
  parameter int GROUP_SIZE_WIDTH = NOF_LEVELS + 1
) (
  input logic              clk,
  input logic              rst,
  pe_mem_scheduler_if.slave bus
);

  typedef enum logic {IDLE, BURST} state_t;

  localparam logic [NOF_LEVELS:0]         PES_EXT = (NOF_LEVELS + 1)'(NOF_PES);
  localparam logic [GROUP_SIZE_WIDTH-1:0] PES_G   = GROUP_SIZE_WIDTH'(NOF_PES);
  localparam logic [NOF_LEVELS-1:0]       LAST_PE = NOF_LEVELS'(NOF_PES - 1);

  state_t                      state;
  state_t                      state_next;

  logic [NOF_LEVELS-1:0]       last_grant;
  logic [NOF_LEVELS-1:0]       owner;
  logic [NOF_LEVELS-1:0]       dest;
  logic [GROUP_SIZE_WIDTH-1:0] group_size;
  logic [GROUP_SIZE_WIDTH-1:0] beat;
  logic [WORD_SIZE-1:0]        data;

  logic                        found;
  logic [NOF_LEVELS-1:0]       winner;
  logic [NOF_LEVELS:0]         cand;
  logic [NOF_LEVELS-1:0]       sel_dest;
  logic [GROUP_SIZE_WIDTH-1:0] sel_size_raw;
  logic [GROUP_SIZE_WIDTH-1:0] sel_size;
  logic [WORD_SIZE-1:0]        sel_data;
  logic                        take;
  logic                        last_beat;
  logic [NOF_LEVELS-1:0]       beat_dest;
  logic [NOF_PES-1:0]          one_hot_base;

  assign take         = (state == IDLE) && found;
  assign last_beat    = (state == BURST) && (beat == group_size - GROUP_SIZE_WIDTH'(1));
  assign beat_dest    = dest + beat[NOF_LEVELS-1:0];
  assign one_hot_base = NOF_PES'(1);
  assign bus.busy     = (state == BURST);

  // Round-robin pick: first requester after last_grant, wrapping mod NOF_PES
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int i = 1; i <= NOF_PES; i++) begin
      cand = {1'b0, last_grant} + (NOF_LEVELS + 1)'(i);
      if (cand >= PES_EXT) cand = cand - PES_EXT;
      if (!found && bus.req[cand[NOF_LEVELS-1:0]]) begin
        found  = 1'b1;
        winner = cand[NOF_LEVELS-1:0];
      end
    end
  end

  // Select the winner's command fields and normalise its group size to 1..NOF_PES
  always_comb begin
    sel_dest     = '0;
    sel_size_raw = '0;
    sel_data     = '0;
    sel_size     = '0;
    for (int p = 0; p < NOF_PES; p++) begin
      if (winner == NOF_LEVELS'(p)) begin
        sel_dest     = bus.req_dest[p*NOF_LEVELS +: NOF_LEVELS];
        sel_size_raw = bus.req_group_size[p*GROUP_SIZE_WIDTH +: GROUP_SIZE_WIDTH];
        sel_data     = bus.req_data[p*WORD_SIZE +: WORD_SIZE];
      end
    end
    if (sel_size_raw == '0)
      sel_size = GROUP_SIZE_WIDTH'(1);
    else if (sel_size_raw > PES_G)
      sel_size = PES_G;
    else
      sel_size = sel_size_raw;
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // FSM next state and grant pulse; grant is held low while reset is asserted
  always_comb begin
    state_next = state;
    bus.grant  = '0;
    case (state)
      IDLE: begin
        if (found && !rst) begin
          state_next = BURST;
          bus.grant  = one_hot_base << winner;
        end
      end
      BURST: begin
        if (last_beat) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Command latch, beat counter and round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= LAST_PE;
      owner      <= '0;
      dest       <= '0;
      group_size <= '0;
      data       <= '0;
      beat       <= '0;
    end else if (take) begin
      owner      <= winner;
      dest       <= sel_dest;
      group_size <= sel_size;
      data       <= sel_data;
      beat       <= '0;
    end else if (state == BURST) begin
      beat <= beat + GROUP_SIZE_WIDTH'(1);
      if (last_beat) last_grant <= owner;
    end
  end

  // Memory beat outputs, held at zero outside a burst
  always_comb begin
    bus.mem_valid         = 1'b0;
    bus.mem_src_pe_index  = '0;
    bus.mem_dest_pe_index = '0;
    bus.mem_input_data    = '0;
    if (state == BURST) begin
      bus.mem_valid         = 1'b1;
      bus.mem_src_pe_index  = owner;
      bus.mem_dest_pe_index = beat_dest;
      bus.mem_input_data    = data;
    end
  end

  // Response register: captures each beat's read word one cycle after the beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rsp_valid      <= 1'b0;
      bus.rsp_pe_index   <= '0;
      bus.rsp_dest_index <= '0;
      bus.rsp_data       <= '0;
      bus.rsp_last       <= 1'b0;
    end else if (state == BURST) begin
      bus.rsp_valid      <= 1'b1;
      bus.rsp_pe_index   <= owner;
      bus.rsp_dest_index <= beat_dest;
      bus.rsp_data       <= bus.mem_output_data;
      bus.rsp_last       <= last_beat;
    end else begin
      bus.rsp_valid      <= 1'b0;
      bus.rsp_pe_index   <= '0;
      bus.rsp_dest_index <= '0;
      bus.rsp_data       <= '0;
      bus.rsp_last       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pe_mem_scheduler.sv
// Testbench for pe_mem_scheduler: directed scenarios plus randomized traffic,
// checked every cycle against a schedule-based model of grants, beats and
// responses.
module tb_pe_mem_scheduler;

  localparam int WS  = 256;
  localparam int NP  = 16;
  localparam int NL  = 4;
  localparam int GW  = 5;
  localparam int RING = 64;

  typedef struct {
    bit            v;
    int            src;
    int            dest;
    logic [WS-1:0] data;
    bit            last;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pe_mem_scheduler_if #(.WORD_SIZE(WS), .NOF_PES(NP)) bus ();

  pe_mem_scheduler #(.WORD_SIZE(WS), .NOF_PES(NP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // memory model: combinational read by dest index
  logic [WS-1:0] mem_array [NP];
  assign bus.mem_output_data = mem_array[bus.mem_dest_pe_index];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // model state
  beat_t mem_ring [RING];
  beat_t rsp_ring [RING];
  int    rr_ptr  = NP - 1;
  int    free_at = 0;
  logic [NP-1:0] seen_grant = '0;

  // observation logs for directed literal checks
  int grant_log[$];
  int grant_cyc_log[$];
  int rsp_dat_log[$];
  int rsp_dest_log[$];
  int rsp_last_log[$];
  int rsp_cyc_log[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [WS-1:0] actual,
                              input logic [WS-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, actual, expected);
    end
  endtask

  function automatic beat_t empty_beat();
    beat_t b;
    b.v = 1'b0; b.src = 0; b.dest = 0; b.data = '0; b.last = 1'b0;
    return b;
  endfunction

  function automatic int q_at(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  function automatic logic [WS-1:0] rand_word();
    logic [WS-1:0] w;
    for (int k = 0; k < WS / 32; k++) w[k*32 +: 32] = $urandom;
    return w;
  endfunction

  // Per-cycle model update and comparison, sampled on the falling edge
  always @(negedge clk) begin : compare
    int s, win, gs, g, d, bd;
    bit fnd;
    logic [NP-1:0] exp_grant;
    logic [WS-1:0] dat;
    beat_t mb, rb;
    if (rst) begin
      for (int i = 0; i < RING; i++) begin
        mem_ring[i] = empty_beat();
        rsp_ring[i] = empty_beat();
      end
      rr_ptr  = NP - 1;
      free_at = 0;
      seen_grant = '0;
      check_output("rst_grant", bus.grant, '0);
      check_output("rst_busy", bus.busy, '0);
      check_output("rst_mem_valid", bus.mem_valid, '0);
      check_output("rst_mem_src", bus.mem_src_pe_index, '0);
      check_output("rst_mem_dest", bus.mem_dest_pe_index, '0);
      check_output("rst_mem_input", bus.mem_input_data, '0);
      check_output("rst_rsp_valid", bus.rsp_valid, '0);
      check_output("rst_rsp_pe", bus.rsp_pe_index, '0);
      check_output("rst_rsp_dest", bus.rsp_dest_index, '0);
      check_output("rst_rsp_data", bus.rsp_data, '0);
      check_output("rst_rsp_last", bus.rsp_last, '0);
    end else begin
      exp_grant = '0;
      if (cyc >= free_at && bus.req != '0) begin
        fnd = 1'b0;
        win = 0;
        for (int i = 1; i <= NP; i++) begin
          if (!fnd && bus.req[(rr_ptr + i) % NP]) begin
            fnd = 1'b1;
            win = (rr_ptr + i) % NP;
          end
        end
        gs  = int'(bus.req_group_size[win*GW +: GW]);
        g   = (gs == 0) ? 1 : ((gs > NP) ? NP : gs);
        d   = int'(bus.req_dest[win*NL +: NL]);
        dat = bus.req_data[win*WS +: WS];
        for (int j = 0; j < g; j++) begin
          bd = (d + j) % NP;
          mb.v = 1'b1; mb.src = win; mb.dest = bd; mb.data = dat; mb.last = (j == g - 1);
          mem_ring[(cyc + 1 + j) % RING] = mb;
          rb.v = 1'b1; rb.src = win; rb.dest = bd; rb.data = mem_array[bd]; rb.last = (j == g - 1);
          rsp_ring[(cyc + 2 + j) % RING] = rb;
        end
        exp_grant[win] = 1'b1;
        free_at = cyc + g + 1;
        rr_ptr  = win;
      end
      s  = cyc % RING;
      mb = mem_ring[s];
      rb = rsp_ring[s];
      check_output("grant", bus.grant, exp_grant);
      check_output("busy", bus.busy, mb.v);
      check_output("mem_valid", bus.mem_valid, mb.v);
      check_output("mem_src", bus.mem_src_pe_index, mb.v ? mb.src : 0);
      check_output("mem_dest", bus.mem_dest_pe_index, mb.v ? mb.dest : 0);
      check_output("mem_input", bus.mem_input_data, mb.v ? mb.data : '0);
      check_output("rsp_valid", bus.rsp_valid, rb.v);
      check_output("rsp_last", bus.rsp_last, rb.v && rb.last);
      if (rb.v) begin
        check_output("rsp_pe", bus.rsp_pe_index, rb.src);
        check_output("rsp_dest", bus.rsp_dest_index, rb.dest);
        check_output("rsp_data", bus.rsp_data, rb.data);
      end
      mem_ring[s] = empty_beat();
      rsp_ring[s] = empty_beat();
      if (bus.grant != '0) begin
        for (int p = 0; p < NP; p++) if (bus.grant[p]) grant_log.push_back(p);
        grant_cyc_log.push_back(cyc);
      end
      if (bus.rsp_valid) begin
        rsp_dat_log.push_back(int'(bus.rsp_data[31:0]));
        rsp_dest_log.push_back(int'(bus.rsp_dest_index));
        rsp_last_log.push_back(int'(bus.rsp_last));
        rsp_cyc_log.push_back(cyc);
      end
      seen_grant = bus.grant;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_stimulus(input int pe, input int d, input int gs, input logic [WS-1:0] dat);
    bus.req[pe] = 1'b1;
    bus.req_dest[pe*NL +: NL] = NL'(d);
    bus.req_group_size[pe*GW +: GW] = GW'(gs);
    bus.req_data[pe*WS +: WS] = dat;
  endtask

  task automatic drop_req(input int pe);
    bus.req[pe] = 1'b0;
  endtask

  task automatic wait_grant(input int limit);
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    while (!got && n < limit) begin
      @(negedge clk);
      n++;
      if (bus.grant != '0) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("[TB] FAIL wait_grant: got no grant within %0d cycles, required one", limit);
    end
  endtask

  task automatic clear_logs();
    grant_log.delete(); grant_cyc_log.delete();
    rsp_dat_log.delete(); rsp_dest_log.delete();
    rsp_last_log.delete(); rsp_cyc_log.delete();
  endtask

  function automatic int sum_q(input int q[$]);
    int t = 0;
    foreach (q[i]) t += q[i];
    return t;
  endfunction

  initial begin
    int mask, cnt7;
    rst = 1'b1;
    bus.req = '0;
    bus.req_dest = '0;
    bus.req_group_size = '0;
    bus.req_data = '0;
    for (int i = 0; i < NP; i++) mem_array[i] = WS'(i + 10);
    tick(3);
    rst = 1'b0;
    tick(3);

    // reset pulse while idle, no requests
    $display("[TB] idle reset pulse");
    clear_logs();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(4);
    check_output("idle_no_grant", grant_log.size(), 0);

    // single burst: PE3, dest 5, G=3
    $display("[TB] single burst");
    clear_logs();
    apply_stimulus(3, 5, 3, WS'('hAB));
    wait_grant(10);
    tick(1);
    drop_req(3);
    tick(6);
    check_output("t2_grant_pe", q_at(grant_log, 0), 3);
    check_output("t2_rsp_count", rsp_dat_log.size(), 3);
    check_output("t2_rsp_data0", q_at(rsp_dat_log, 0), 15);
    check_output("t2_rsp_data1", q_at(rsp_dat_log, 1), 16);
    check_output("t2_rsp_data2", q_at(rsp_dat_log, 2), 17);
    check_output("t2_rsp_dest2", q_at(rsp_dest_log, 2), 7);
    check_output("t2_last_flags", {q_at(rsp_last_log, 0), q_at(rsp_last_log, 1), q_at(rsp_last_log, 2)} & 'h7, 'h1);
    check_output("t2_last_latency", q_at(rsp_cyc_log, 2) - q_at(grant_cyc_log, 0), 4);

    // wrap-around: PE0, dest 14, G=4
    $display("[TB] wrap-around");
    clear_logs();
    apply_stimulus(0, 14, 4, rand_word());
    wait_grant(10);
    tick(1);
    drop_req(0);
    tick(7);
    check_output("t3_dest0", q_at(rsp_dest_log, 0), 14);
    check_output("t3_dest1", q_at(rsp_dest_log, 1), 15);
    check_output("t3_dest2", q_at(rsp_dest_log, 2), 0);
    check_output("t3_dest3", q_at(rsp_dest_log, 3), 1);
    check_output("t3_data0", q_at(rsp_dat_log, 0), 24);
    check_output("t3_data2", q_at(rsp_dat_log, 2), 10);
    check_output("t3_data3", q_at(rsp_dat_log, 3), 11);

    // group size edges
    $display("[TB] group size edges");
    clear_logs();
    apply_stimulus(5, 2, 0, rand_word());
    wait_grant(10);
    tick(1);
    drop_req(5);
    tick(4);
    check_output("t4_g0_count", rsp_dat_log.size(), 1);
    check_output("t4_g0_last", q_at(rsp_last_log, 0), 1);
    clear_logs();
    apply_stimulus(6, 9, 31, rand_word());
    wait_grant(10);
    tick(1);
    drop_req(6);
    tick(20);
    check_output("t4_g31_count", rsp_dat_log.size(), 16);
    check_output("t4_g31_last_total", sum_q(rsp_last_log), 1);
    check_output("t4_g31_last_pos", q_at(rsp_last_log, 15), 1);
    mask = 0;
    foreach (rsp_dest_log[i]) mask |= (1 << rsp_dest_log[i]);
    check_output("t4_g31_cover", mask, 'hFFFF);

    // reset during a G=8 burst at beat 3, PE0 waiting
    $display("[TB] reset mid-burst");
    clear_logs();
    apply_stimulus(4, 0, 8, rand_word());
    wait_grant(10);
    tick(1);
    drop_req(4);
    tick(3);
    apply_stimulus(0, 3, 2, rand_word());
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check_output("t1_rsp_before_reset", rsp_dat_log.size(), 2);
    check_output("t1_no_last", sum_q(rsp_last_log), 0);
    wait_grant(5);
    tick(1);
    drop_req(0);
    check_output("t1_grant_after_reset", q_at(grant_log, 1), 0);
    tick(6);

    // round-robin fairness with held requests
    $display("[TB] round-robin");
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    clear_logs();
    apply_stimulus(1, 1, 1, rand_word());
    apply_stimulus(2, 7, 1, rand_word());
    apply_stimulus(9, 12, 1, rand_word());
    repeat (6) wait_grant(10);
    tick(1);
    drop_req(1);
    drop_req(2);
    drop_req(9);
    tick(4);
    check_output("t5_count", grant_log.size(), 6);
    check_output("t5_g0", q_at(grant_log, 0), 1);
    check_output("t5_g1", q_at(grant_log, 1), 2);
    check_output("t5_g2", q_at(grant_log, 2), 9);
    check_output("t5_g3", q_at(grant_log, 3), 1);
    check_output("t5_g4", q_at(grant_log, 4), 2);
    check_output("t5_g5", q_at(grant_log, 5), 9);
    for (int k = 1; k < 6; k++)
      check_output("t5_spacing", q_at(grant_cyc_log, k) - q_at(grant_cyc_log, k - 1), 2);

    // dropped request while another PE is bursting
    $display("[TB] dropped request");
    clear_logs();
    apply_stimulus(2, 4, 8, rand_word());
    wait_grant(10);
    tick(1);
    drop_req(2);
    tick(1);
    apply_stimulus(7, 0, 1, rand_word());
    tick(1);
    drop_req(7);
    tick(12);
    cnt7 = 0;
    foreach (grant_log[i]) if (grant_log[i] == 7) cnt7++;
    check_output("t6_pe7_grants", cnt7, 0);
    check_output("t6_grant_count", grant_log.size(), 1);
    check_output("t6_busy_low", bus.busy, 1'b0);

    // randomized traffic
    $display("[TB] random traffic");
    for (int i = 0; i < NP; i++) mem_array[i] = rand_word();
    tick(2);
    for (int c = 0; c < 2000; c++) begin
      for (int p = 0; p < NP; p++) begin
        if (bus.req[p] && seen_grant[p]) begin
          if ($urandom_range(1) == 0) drop_req(p);
        end else if (!bus.req[p]) begin
          if ($urandom_range(7) == 0)
            apply_stimulus(p, int'($urandom_range(NP - 1)), int'($urandom_range(31)), rand_word());
        end else if ($urandom_range(15) == 0) begin
          drop_req(p);
        end
      end
      if ($urandom_range(499) == 0) begin
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
      end
      tick(1);
    end
    bus.req = '0;
    tick(25);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pe_mem_scheduler.md
Name: pe_mem_scheduler

Overview:
- Round-robin arbiter and burst sequencer that shares the single-port PE memory between NOF_PES requesting PEs.
- Each winning requester issues one command: a write word and a dest PE index and group size. The scheduler steps the memory's src/dest indices across the dest group, one beat per cycle.
- It returns each read word with registered response signals.
- It sits between the PE request fabric and the PE memory datapath.

Parameters:
- WORD_SIZE, 256, data word width.
- NOF_PES, 16, number of PEs and requesters.
- NOF_LEVELS, $clog2(NOF_PES), PE index width.
- GROUP_SIZE_WIDTH, NOF_LEVELS+1, group size field width.

Ports:
- clk  input  1  single clock, all state rising-edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  NOF_PES  per-PE request level; held until granted.
- req_dest  input  NOF_PES*NOF_LEVELS  per-PE base dest index; PE p uses slice p.
- req_group_size  input  NOF_PES*GROUP_SIZE_WIDTH  per-PE dest group size; PE p uses slice p.
- req_data  input  NOF_PES*WORD_SIZE  per-PE write word; PE p uses slice p.
- grant  output  NOF_PES  one-hot, one-cycle pulse; the command is latched in the same cycle.
- busy  output  1  high while in BURST.
- mem_input_data  output  WORD_SIZE  to memory input_data.
- mem_src_pe_index  output  NOF_LEVELS  to memory src_pe_index.
- mem_dest_pe_index  output  NOF_LEVELS  to memory dest_pe_index.
- mem_valid  output  1  high on each active beat.
- mem_output_data  input  WORD_SIZE  memory read word, combinational from mem_dest_pe_index.
- rsp_valid  output  1  registered response strobe.
- rsp_pe_index  output  NOF_LEVELS  owner (requester) of the response.
- rsp_dest_index  output  NOF_LEVELS  dest index the response word was read from.
- rsp_data  output  WORD_SIZE  captured mem_output_data.
- rsp_last  output  1  marks the final beat of a burst.

Behaviour:
- Reset (async, rst=1):
  - FSM goes to IDLE; round-robin pointer last_grant = NOF_PES-1, so PE0 has top priority first.
  - All outputs are 0: grant, busy, mem_*, rsp_*.
  - Reset mid-burst aborts the burst: no further beats, no rsp_last.
- FSM states: IDLE, BURST.
- IDLE:
  - If req != 0, pick the first set bit scanning from last_grant+1 upward, wrapping mod NOF_PES.
  - Pulse the grant bit for that PE and latch owner, dest, group size and data.
  - Set beat counter k=0 and go to BURST.
  - If req == 0, stay in IDLE with grant=0.
- Group size normalisation at latch:
  - 0 is treated as 1.
  - Values > NOF_PES are clipped to NOF_PES.
  - Latched size G ranges 1..NOF_PES.
- BURST, each cycle:
  - mem_valid=1, mem_src_pe_index=owner, mem_input_data=latched data.
  - mem_dest_pe_index = (dest + k) mod NOF_PES; wraps, e.g. dest=14, G=4 gives 14,15,0,1.
  - k increments each cycle.
  - On the beat with k == G-1, update last_grant=owner and return to IDLE.
- Outside BURST: mem_valid=0; mem_* indices and data hold 0.
- Response path: registered. The beat driven in cycle t produces, in cycle t+1:
  - rsp_valid=1, rsp_data = mem_output_data sampled at t;
  - rsp_pe_index=owner, rsp_dest_index = beat index;
  - rsp_last=1 only for beat G-1.
- Timing: grant in cycle T; beats T+1..T+G; responses T+2..T+G+1.
  - The next grant can occur no earlier than T+G+1, so there is one idle memory cycle between bursts.
- Requests:
  - Requests are not sampled during BURST; grant is only ever issued from IDLE.
  - A req deasserted before grant is dropped silently.
  - Multiple simultaneous reqs are served one burst each in round-robin order.
  - A PE that keeps req high after its burst goes behind all other pending requesters.
- busy = (state == BURST).
- Internal counters use width GROUP_SIZE_WIDTH; the index add is truncated to NOF_LEVELS bits for the wrap.

Test Plan:
1. Reset then idle: rst pulsed mid-sim with no req -> all outputs 0, grant never asserts. Assert rst during a G=8 burst at beat 3 -> mem_valid and rsp_valid drop asynchronously; no rsp_last; after release the next grant goes to PE0 if requesting.
2. Single burst: memory model word i = i+10; PE3 requests dest=5, G=3, data=0xAB -> grant=0x0008 at T; mem_dest 5,6,7 at T+1..T+3 with mem_src=3 and input 0xAB; rsp_data 15,16,17 at T+2..T+4; rsp_last at T+4.
3. Wrap-around: PE0 requests dest=14, G=4 -> rsp_dest_index 14,15,0,1; rsp_data 24,25,10,11.
4. Group size edges: G=0 -> exactly 1 beat with rsp_last. G=31 at NOF_PES=16 -> exactly 16 beats covering every dest once.
5. Round-robin fairness: PEs 1, 2 and 9 hold req continuously with G=1 -> grants 1,2,9,1,2,9…. Each grant is separated by exactly 2 cycles; no PE is granted twice before the others.
6. Dropped request: PE7 raises req for one cycle while PE2 is in BURST, then lowers it -> PE7 is never granted; busy deasserts after PE2's final beat.
